// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with signs applied on the final step.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             in_ready,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITER = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd_mag;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_ovf;
    logic [TAG_W-1:0]   tag_r;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_hi_n;
    logic [WIDTH-1:0]   div_lo_n;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               is_div_ovf;

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    always_comb begin
        abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
        abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
        is_div_ovf = (operand_a == MIN_VAL) && (operand_b == '1);

        // acc_lo holds the multiplier; product bits shift in from the top
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_mag : '0)};
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

        // acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_mag};
        if (div_diff[WIDTH]) begin
            div_hi_n = div_shift[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end else begin
            div_hi_n = div_diff[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end

        prod_mag = {mul_hi_n, mul_lo_n};
        prod     = neg_lo ? -prod_mag : prod_mag;
        mul_ovf  = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        quot     = neg_lo ? -div_lo_n : div_lo_n;
        rem      = neg_hi ? -div_hi_n : div_hi_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd_mag  <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_ovf   <= 1'b0;
            tag_r     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            exception <= 1'b0;
            tag_out   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            result_lo <= '0;
            result_hi <= '0;
            exception <= 1'b0;
            tag_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        tag_r  <= tag_in;
                        count  <= ITER;
                        acc_hi <= '0;
                        if (start_mult) begin
                            state    <= MULT;
                            opnd_mag <= abs_a;
                            acc_lo   <= abs_b;
                            neg_lo   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            neg_hi   <= 1'b0;
                            div_ovf  <= 1'b0;
                        end else if (operand_b == '0) begin
                            state     <= DONE;
                            result_lo <= '0;
                            result_hi <= '0;
                            exception <= 1'b1;
                            tag_out   <= tag_in;
                        end else begin
                            state    <= DIV;
                            opnd_mag <= abs_b;
                            acc_lo   <= abs_a;
                            neg_lo   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            neg_hi   <= operand_a[WIDTH-1];
                            div_ovf  <= is_div_ovf;
                        end
                    end
                end
                MULT: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        result_hi <= prod[2*WIDTH-1:WIDTH];
                        result_lo <= prod[WIDTH-1:0];
                        exception <= mul_ovf;
                        tag_out   <= tag_r;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        result_lo <= quot;
                        result_hi <= rem;
                        exception <= div_ovf;
                        tag_out   <= tag_r;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state     <= IDLE;
                        result_lo <= '0;
                        result_hi <= '0;
                        exception <= 1'b0;
                        tag_out   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq (WIDTH=32): hand-computed products, quotients,
// latencies, result hold, flush and reset aborts.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        start_mult;
    logic        start_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  tag_in;
    logic        in_ready;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        exception;
    logic [4:0]  tag_out;

    int checks = 0;
    int failures = 0;

    multdiv_seq #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .start_mult(start_mult),
        .start_div(start_div),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .tag_in(tag_in),
        .in_ready(in_ready),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_lo(result_lo),
        .result_hi(result_hi),
        .exception(exception),
        .tag_out(tag_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic is_mult, input logic both,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_exc, input int hold);
        int lat;
        operand_a  = a;
        operand_b  = b;
        tag_in     = tag;
        start_mult = is_mult | both;
        start_div  = ~is_mult | both;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        tag_in     = ~tag;
        lat = 1;
        while (!result_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_eq({name, ".lat"}, 64'(lat), 64'(exp_lat));
        check_eq({name, ".lo"}, 64'(result_lo), 64'(exp_lo));
        check_eq({name, ".hi"}, 64'(result_hi), 64'(exp_hi));
        check_eq({name, ".exc"}, 64'(exception), 64'(exp_exc));
        check_eq({name, ".tag"}, 64'(tag_out), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            start_mult = 1'b1;
            start_div  = i[0];
            tick();
            check_eq({name, ".hold_lo"}, 64'(result_lo), 64'(exp_lo));
            check_eq({name, ".hold_hi"}, 64'(result_hi), 64'(exp_hi));
            check_eq({name, ".hold_flags"}, {57'd0, result_valid, in_ready, exception, tag_out},
                     {57'd0, 1'b1, 1'b0, exp_exc, tag});
        end
        start_mult   = 1'b0;
        start_div    = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq({name, ".post_ready"}, 64'(in_ready), 64'd1);
        check_eq({name, ".post_valid"}, 64'(result_valid), 64'd0);
        check_eq({name, ".post_lo"}, 64'(result_lo), 64'd0);
        check_eq({name, ".post_tag"}, 64'(tag_out), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_valid;
        reset = 1'b1; flush = 1'b0; start_mult = 1'b0; start_div = 1'b0;
        operand_a = '0; operand_b = '0; tag_in = '0; result_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst.in_ready", 64'(in_ready), 64'd1);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.valid", 64'(result_valid), 64'd0);
        check_eq("rst.lo", 64'(result_lo), 64'd0);
        check_eq("rst.hi", 64'(result_hi), 64'd0);
        check_eq("rst.exc_tag", {58'd0, exception, tag_out}, 64'd0);

        run_op("mul_7xm6",   1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFA, 5'd3,  33, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 5);
        run_op("mul_ovf",    1'b1, 1'b0, 32'h40000000, 32'h00000004, 5'd4,  33, 32'h00000000, 32'h00000001, 1'b1, 0);
        run_op("div_m7_2",   1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000002, 5'd5,  33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
        run_op("div_minm1",  1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd6,  33, 32'h80000000, 32'h00000000, 1'b1, 0);
        run_op("div_by0",    1'b0, 1'b0, 32'h00000005, 32'h00000000, 5'd7,  1,  32'h00000000, 32'h00000000, 1'b1, 0);
        run_op("both_start", 1'b1, 1'b1, 32'h00000003, 32'h00000005, 5'd8,  33, 32'h0000000F, 32'h00000000, 1'b0, 0);
        run_op("mul_minm1",  1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd9,  33, 32'h80000000, 32'h00000000, 1'b1, 0);
        run_op("mul_m5m5",   1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 5'd10, 33, 32'h00000019, 32'h00000000, 1'b0, 0);
        run_op("mul_minmin", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 5'd11, 33, 32'h00000000, 32'h40000000, 1'b1, 0);
        run_op("div_100_m7", 1'b0, 1'b0, 32'h00000064, 32'hFFFFFFF9, 5'd12, 33, 32'hFFFFFFF2, 32'h00000002, 1'b0, 0);
        run_op("div_m100_7", 1'b0, 1'b0, 32'hFFFFFF9C, 32'h00000007, 5'd13, 33, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 0);
        run_op("div_7_min",  1'b0, 1'b0, 32'h00000007, 32'h80000000, 5'd31, 33, 32'h00000000, 32'h00000007, 1'b0, 0);

        flush = 1'b1; start_mult = 1'b1; operand_a = 32'd2; operand_b = 32'd3;
        tick();
        flush = 1'b0; start_mult = 1'b0;
        check_eq("flush_blocks_accept", 64'(in_ready), 64'd1);

        operand_a = 32'd100; operand_b = 32'd7; tag_in = 5'd20; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        saw_valid = 1'b0;
        repeat (9) begin
            tick();
            saw_valid |= result_valid;
        end
        check_eq("flush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush.in_ready", 64'(in_ready), 64'd1);
        check_eq("flush.busy", 64'(busy), 64'd0);
        repeat (40) begin
            tick();
            saw_valid |= result_valid;
        end
        check_eq("flush.no_valid", 64'(saw_valid), 64'd0);

        operand_a = 32'd3; operand_b = 32'd4; tag_in = 5'd21; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        saw_valid = 1'b0;
        repeat (5) begin
            tick();
            saw_valid |= result_valid;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rstmid.in_ready", 64'(in_ready), 64'd1);
        check_eq("rstmid.lo_tag", {27'd0, result_lo, tag_out}, 64'd0);
        repeat (40) begin
            tick();
            saw_valid |= result_valid;
        end
        check_eq("rstmid.no_valid", 64'(saw_valid), 64'd0);

        run_op("after_rst",  1'b1, 1'b0, 32'h00000006, 32'h00000007, 5'd1,  33, 32'h0000002A, 32'h00000000, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width (even, >=4).
REQ-002 Parameter TAG_W, default 5, sets the destination-register tag width.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 start_mult  input  1  request signed multiply.
REQ-007 start_div  input  1  request signed divide.
REQ-008 operand_a  input  WIDTH  multiplicand or dividend.
REQ-009 operand_b  input  WIDTH  multiplier or divisor.
REQ-010 tag_in  input  TAG_W  destination tag, captured at accept.
REQ-011 in_ready  output  1  unit idle and able to accept.
REQ-012 busy  output  1  operation in flight or result pending; drives pipeline stall.
REQ-013 result_valid  output  1  result_lo, result_hi, exception and tag_out are valid.
REQ-014 result_ready  input  1  consumer takes the result.
REQ-015 result_lo  output  WIDTH  product low half or quotient.
REQ-016 result_hi  output  WIDTH  product high half or remainder.
REQ-017 exception  output  1  multiply overflow, divide by zero, or divide overflow.
REQ-018 tag_out  output  TAG_W  tag of the current result.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, MULT, DIV and DONE.
REQ-020 in_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE); result_valid SHALL equal (state==DONE).
REQ-021 An accept SHALL occur on a rising edge when in_ready=1, flush=0 and start_mult or start_div is 1; operands and tag_in are registered at that edge.
REQ-022 If start_mult and start_div are both 1, the unit SHALL perform a multiply.
REQ-023 Start pulses while not in IDLE SHALL be ignored and SHALL NOT corrupt the in-flight operation.
REQ-024 A multiply SHALL iterate for exactly WIDTH cycles; result_valid SHALL rise in cycle N+WIDTH+1 for an accept in cycle N.
REQ-025 The multiply result SHALL be the full 2*WIDTH signed product, with {result_hi,result_lo}=a*b.
REQ-026 The multiply exception SHALL be 1 iff the product is not representable in WIDTH signed bits, i.e. result_hi is not the sign extension of result_lo[WIDTH-1].
REQ-027 A divide with a nonzero divisor SHALL iterate for exactly WIDTH cycles, with result_valid in cycle N+WIDTH+1.
REQ-028 Divide SHALL truncate toward zero; the remainder SHALL take the dividend's sign, with a == q*b + r and |r| < |b|.
REQ-029 A divide by zero SHALL go directly to DONE, with result_valid in cycle N+1, result_lo=0, result_hi=0 and exception=1.
REQ-030 A divide of the most-negative value by -1 SHALL return result_lo=MIN, result_hi=0 and exception=1, with normal WIDTH-cycle latency.
REQ-031 The iteration counter SHALL be $clog2(WIDTH)+1 bits and SHALL be reloaded on every accept.
REQ-032 In DONE, all result outputs SHALL be held stable until result_ready=1 is sampled; the state SHALL then go to IDLE on that edge.
REQ-033 A new accept SHALL NOT occur in the same cycle a result is consumed; the earliest back-to-back accept is the cycle after consumption.
REQ-034 flush=1 SHALL force IDLE on the next edge from any state, discard any pending result and block any accept in the same cycle.
REQ-035 While not in DONE, result_lo, result_hi, exception and tag_out SHALL be 0.

Reset
REQ-036 reset=1 SHALL force IDLE and clear all datapath registers, the counter and the tag; reset takes priority over flush and starts.
REQ-037 After reset: in_ready=1, busy=0, result_valid=0, and result_lo, result_hi, exception and tag_out are all 0.
REQ-038 A reset asserted mid-operation SHALL abort the operation with no result_valid pulse.

Verification (WIDTH=32)
REQ-039 Multiply 7 * 0xFFFFFFFA, accepted in cycle N -> in cycle N+33: result_valid=1, result_lo=0xFFFFFFD6, result_hi=0xFFFFFFFF, exception=0, with tag echoed.
REQ-040 Multiply 0x40000000 * 4 -> result_lo=0x00000000, result_hi=0x00000001, exception=1.
REQ-041 Divide 0xFFFFFFF9 / 2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF, exception=0, valid in cycle N+33; divide 0x80000000 / 0xFFFFFFFF -> result_lo=0x80000000, result_hi=0, exception=1.
REQ-042 Divide 5 / 0 -> result_valid in cycle N+1, result_lo=0, result_hi=0, exception=1.
REQ-043 Hold result_ready=0 for 5 cycles after result_valid -> outputs stay stable and start pulses are ignored; after result_ready=1, in_ready=1 on the next cycle.
REQ-044 flush in cycle N+10 of a divide -> in_ready=1 in cycle N+11 and result_valid is never asserted; a reset mid-multiply behaves the same.
